// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, turns MEM-stage
// exception/ertn events into a one-cycle flush with redirect PC, and parks on idle.
module pipe_ctrl #(
    parameter int STALL_WD = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                excp_valid,
    input  logic                excp_ertn,
    input  logic                excp_idle,
    input  logic                int_pending,
    input  logic [31:0]         csr_eentry,
    input  logic [31:0]         csr_era,
    output logic [STALL_WD-1:0] stall,
    output logic                flush,
    output logic [31:0]         flush_pc,
    output logic                excp_commit,
    output logic                ertn_commit,
    output logic                idle_state,
    output logic [31:0]         stall_cnt
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;

    // Deeper requests freeze every earlier stage as well.
    localparam logic [STALL_WD-1:0] MASK_IF  = STALL_WD'(6'b000001);
    localparam logic [STALL_WD-1:0] MASK_ID  = STALL_WD'(6'b000011);
    localparam logic [STALL_WD-1:0] MASK_EX  = STALL_WD'(6'b000111);
    localparam logic [STALL_WD-1:0] MASK_MEM = STALL_WD'(6'b001111);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       kind_ertn;
    logic       accept_excp;
    logic       accept_idle;

    // A stalled MEM instruction is presented again, so its event waits.
    assign accept_excp = (state == S_RUN) && !stallreq_mem && excp_valid;
    assign accept_idle = (state == S_RUN) && !stallreq_mem && !excp_valid && excp_idle;

    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        stall     = '0;
        case (state)
            S_RUN: begin
                if (stallreq_if)  stall = stall | MASK_IF;
                if (stallreq_id)  stall = stall | MASK_ID;
                if (stallreq_ex)  stall = stall | MASK_EX;
                if (stallreq_mem) stall = stall | MASK_MEM;
                if (accept_excp)      state_nxt = S_FLUSH;
                else if (accept_idle) state_nxt = S_IDLE;
            end
            S_FLUSH: state_nxt = S_RUN;
            S_IDLE: begin
                stall = MASK_EX;
                if (int_pending) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            flush_pc  <= '0;
            kind_ertn <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_excp) begin
                flush_pc  <= excp_ertn ? csr_era : csr_eentry;
                kind_ertn <= excp_ertn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall[0] && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign flush       = (state == S_FLUSH);
    assign excp_commit = flush && !kind_ertn;
    assign ertn_commit = flush && kind_ertn;
    assign idle_state  = (state == S_IDLE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected per-cycle outputs are queued with a due
// cycle when stimulus is applied and compared by a negedge monitor.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid, excp_ertn, excp_idle, int_pending;
    logic [31:0] csr_eentry, csr_era;
    logic [5:0]  stall;
    logic        flush, excp_commit, ertn_commit, idle_state;
    logic [31:0] flush_pc, stall_cnt;

    pipe_ctrl #(.STALL_WD(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_valid   (excp_valid),
        .excp_ertn    (excp_ertn),
        .excp_idle    (excp_idle),
        .int_pending  (int_pending),
        .csr_eentry   (csr_eentry),
        .csr_era      (csr_era),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .excp_commit  (excp_commit),
        .ertn_commit  (ertn_commit),
        .idle_state   (idle_state),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        int          due;
        string       tag;
        logic [5:0]  st;
        logic        fl;
        logic        ec;
        logic        er;
        logic        idl;
        logic        chk_pc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_check++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input int off, input string tag, input logic [5:0] st,
                           input logic fl, input logic ec, input logic er, input logic idl,
                           input logic chk_pc, input logic [31:0] pc);
        exp_t e;
        e.due = cyc + off; e.tag = tag; e.st = st; e.fl = fl; e.ec = ec;
        e.er = er; e.idl = idl; e.chk_pc = chk_pc; e.pc = pc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check({sb[i].tag, ".stall"},       32'(stall),       32'(sb[i].st));
                check({sb[i].tag, ".flush"},       32'(flush),       32'(sb[i].fl));
                check({sb[i].tag, ".excp_commit"}, 32'(excp_commit), 32'(sb[i].ec));
                check({sb[i].tag, ".ertn_commit"}, 32'(ertn_commit), 32'(sb[i].er));
                check({sb[i].tag, ".idle_state"},  32'(idle_state),  32'(sb[i].idl));
                if (sb[i].chk_pc) check({sb[i].tag, ".flush_pc"}, flush_pc, sb[i].pc);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cnt0;
        reset = 1'b1;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = '0;
        {excp_valid, excp_ertn, excp_idle, int_pending} = '0;
        csr_eentry = 32'h1C00_8000;
        csr_era    = 32'h1C00_0104;
        tick(); tick();

        // Reset state
        reset = 1'b0;
        exp_out(0, "reset", 6'b000000, 0, 0, 0, 0, 1, 32'h0);
        check("reset.stall_cnt", stall_cnt, 32'd0);

        // Stall masks, including OR of simultaneous requests
        tick(); stallreq_id = 1'b1;
        exp_out(0, "mask_id", 6'b000011, 0, 0, 0, 0, 0, 0);
        tick(); stallreq_id = 1'b0; stallreq_ex = 1'b1;
        exp_out(0, "mask_ex", 6'b000111, 0, 0, 0, 0, 0, 0);
        tick(); stallreq_ex = 1'b0; stallreq_id = 1'b1; stallreq_mem = 1'b1;
        exp_out(0, "mask_id_mem", 6'b001111, 0, 0, 0, 0, 0, 0);
        tick(); stallreq_id = 1'b0; stallreq_mem = 1'b0; stallreq_if = 1'b1;
        exp_out(0, "mask_if", 6'b000001, 0, 0, 0, 0, 0, 0);
        tick(); stallreq_if = 1'b0;
        exp_out(0, "mask_none", 6'b000000, 0, 0, 0, 0, 0, 0);
        tick();
        check("masks.stall_cnt", stall_cnt, 32'd4);

        // Plain exception
        excp_valid = 1'b1;
        exp_out(0, "excp_t",  6'b000000, 0, 0, 0, 0, 0, 0);
        exp_out(1, "excp_t1", 6'b000000, 1, 1, 0, 0, 1, 32'h1C00_8000);
        exp_out(2, "excp_t2", 6'b000000, 0, 0, 0, 0, 1, 32'h1C00_8000);
        tick(); excp_valid = 1'b0;
        tick(); tick();

        // ertn held back by a 3-cycle MEM stall, excp_valid kept high through FLUSH
        excp_valid = 1'b1; excp_ertn = 1'b1; stallreq_mem = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_out(0, "ertn_stalled", 6'b001111, 0, 0, 0, 0, 0, 0);
            tick();
        end
        stallreq_mem = 1'b0;
        exp_out(0, "ertn_accept", 6'b000000, 0, 0, 0, 0, 0, 0);
        exp_out(1, "ertn_flush",  6'b000000, 1, 0, 1, 0, 1, 32'h1C00_0104);
        exp_out(2, "ertn_after",  6'b000000, 0, 0, 0, 0, 1, 32'h1C00_0104);
        tick();
        tick(); excp_valid = 1'b0; excp_ertn = 1'b0;
        exp_out(1, "ertn_quiet", 6'b000000, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Idle: park for 5 cycles, stall requests ignored, wake on int_pending
        cnt0 = stall_cnt;
        excp_idle = 1'b1;
        exp_out(0, "idle_t", 6'b000000, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) exp_out(k, "idle_in", 6'b000111, 0, 0, 0, 1, 0, 0);
        exp_out(6, "idle_exit", 6'b000000, 0, 0, 0, 0, 0, 0);
        tick(); excp_idle = 1'b0; stallreq_mem = 1'b1;
        tick(); stallreq_id = 1'b1;
        tick(); stallreq_mem = 1'b0; stallreq_id = 1'b0;
        tick();
        tick(); int_pending = 1'b1;
        tick(); int_pending = 1'b0;
        check("idle.stall_cnt", stall_cnt, cnt0 + 32'd5);
        tick();

        // Collision: exception beats idle; held excp_valid during FLUSH is dropped
        excp_valid = 1'b1; excp_idle = 1'b1;
        exp_out(0, "coll_t",  6'b000000, 0, 0, 0, 0, 0, 0);
        exp_out(1, "coll_t1", 6'b000000, 1, 1, 0, 0, 1, 32'h1C00_8000);
        exp_out(2, "coll_t2", 6'b000000, 0, 0, 0, 0, 0, 0);
        exp_out(3, "coll_t3", 6'b000000, 0, 0, 0, 0, 0, 0);
        tick();
        tick(); excp_valid = 1'b0; excp_idle = 1'b0;
        tick(); tick();

        // Reset while parked in IDLE
        excp_idle = 1'b1;
        tick(); excp_idle = 1'b0; reset = 1'b1;
        exp_out(0, "rst_idle_pre", 6'b000111, 0, 0, 0, 1, 0, 0);
        exp_out(1, "rst_idle",     6'b000000, 0, 0, 0, 0, 1, 32'h0);
        tick(); reset = 1'b0;
        check("rst_idle.stall_cnt", stall_cnt, 32'd0);
        tick();

        // Reset during the FLUSH cycle
        excp_valid = 1'b1;
        exp_out(1, "rst_flush_pre", 6'b000000, 1, 1, 0, 0, 1, 32'h1C00_8000);
        exp_out(2, "rst_flush",     6'b000000, 0, 0, 0, 0, 1, 32'h0);
        tick(); excp_valid = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0;
        tick();

        // Counter saturation from a preloaded value
        dut.stall_cnt = 32'hFFFF_FFFE;
        stallreq_if = 1'b1;
        exp_out(0, "sat_stall", 6'b000001, 0, 0, 0, 0, 0, 0);
        tick();
        check("sat.first", stall_cnt, 32'hFFFF_FFFF);
        tick(); tick();
        check("sat.hold", stall_cnt, 32'hFFFF_FFFF);
        stallreq_if = 1'b0;
        tick(); tick();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
